cyc_acct_csr_bridge: RTL

Sequencer between the CSR file and the cycle-accounting counter block. Accepts CSR instruction requests (read/write/set/clear) over a valid/ready handshake. Converts each request into a read, and where needed a single-cycle write, on the counter block's SRAM-like port. Returns the old value, or an exception, over a valid/ready response channel.

---
 rtl/cyc_acct_csr_bridge_if.sv | 29 ++
 rtl/cyc_acct_csr_bridge.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cyc_acct_csr_bridge_if.sv
// Bundle for the CSR-side request/response handshake and the counter-block SRAM-like port.
// The bridge uses the slave modport; the CSR file and the counter block together form the master side.
interface cyc_acct_csr_bridge_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            req_valid;
  logic            req_ready;
  logic [11:0]     req_addr;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_exc;
  logic [11:0]     cnt_addr;
  logic            cnt_we;
  logic [XLEN-1:0] cnt_wdata;
  logic [XLEN-1:0] cnt_rdata;

  modport slave (
    input  req_valid, req_addr, req_op, req_wdata, rsp_ready, cnt_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_exc, cnt_addr, cnt_we, cnt_wdata
  );

  modport master (
    output req_valid, req_addr, req_op, req_wdata, rsp_ready, cnt_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_exc, cnt_addr, cnt_we, cnt_wdata
  );
endinterface

// File: rtl/cyc_acct_csr_bridge.sv
// Sequences one CSR read/write/set/clear into a counter-block read plus at most one write pulse,
// then returns the pre-modification value or an exception.
module cyc_acct_csr_bridge #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned CycAccountRegs = 8,
  parameter logic [11:0] CsrCntStatus   = 12'h7C0,
  parameter logic [11:0] CsrCntData     = 12'h7C1,
  parameter logic [11:0] CsrCntDataH    = 12'h7C2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  cyc_acct_csr_bridge_if.slave        bus_io
);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e          state_q, state_d;
  logic [11:0]     addr_q, addr_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] new_q, new_d;
  logic            exc_q, exc_d;

  logic [XLEN-1:0] new_val;
  logic            addr_legal;
  logic            skip_write;
  logic            status_bad;

  always_comb begin
    new_val = bus_io.req_wdata;
    if (op_q == OpWrite) begin
      new_val = wdata_q;
    end else if (op_q == OpSet) begin
      new_val = bus_io.cnt_rdata | wdata_q;
    end else begin
      new_val = bus_io.cnt_rdata & ~wdata_q;
    end
  end

  assign addr_legal = (addr_q == CsrCntData) || (addr_q == CsrCntStatus) ||
                      ((XLEN == 32) && (addr_q == CsrCntDataH));
  assign skip_write = (op_q == OpRead) || ((op_q != OpWrite) && (wdata_q == '0));
  // Status fields must select an existing counter, otherwise the counter block would misbehave.
  assign status_bad = (addr_q == CsrCntStatus) &&
                      ((32'(new_val[15:0]) >= CycAccountRegs) ||
                       (32'(new_val[31:16]) >= CycAccountRegs));

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    op_d             = op_q;
    wdata_d          = wdata_q;
    old_d            = old_q;
    new_d            = new_q;
    exc_d            = exc_q;
    bus_io.req_ready = 1'b0;
    bus_io.rsp_valid = 1'b0;
    bus_io.rsp_rdata = '0;
    bus_io.rsp_exc   = 1'b0;
    bus_io.cnt_addr  = '0;
    bus_io.cnt_we    = 1'b0;
    bus_io.cnt_wdata = '0;

    unique case (state_q)
      StIdle: begin
        bus_io.req_ready = ~rst_i;
        if (bus_io.req_valid) begin
          addr_d  = bus_io.req_addr;
          op_d    = bus_io.req_op;
          wdata_d = bus_io.req_wdata;
          old_d   = '0;
          new_d   = '0;
          exc_d   = 1'b0;
          state_d = StRead;
        end
      end
      StRead: begin
        bus_io.cnt_addr = addr_q;
        old_d           = bus_io.cnt_rdata;
        new_d           = new_val;
        if (!addr_legal) begin
          exc_d   = 1'b1;
          old_d   = '0;
          state_d = StResp;
        end else if (skip_write) begin
          state_d = StResp;
        end else if (status_bad) begin
          exc_d   = 1'b1;
          old_d   = '0;
          state_d = StResp;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        // The counter block freezes while we is high, so this is the only cycle it is asserted.
        bus_io.cnt_addr  = addr_q;
        bus_io.cnt_we    = 1'b1;
        bus_io.cnt_wdata = new_q;
        state_d          = StResp;
      end
      StResp: begin
        bus_io.rsp_valid = 1'b1;
        bus_io.rsp_rdata = old_q;
        bus_io.rsp_exc   = exc_q;
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      new_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      new_q   <= new_d;
      exc_q   <= exc_d;
    end
  end

endmodule
